// File: rtl/debounce_pkg.sv
// Shared types and default constants for the key debouncer and its input synchronizer.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_TO_HIGH = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_TO_LOW = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 32'd2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 32'd50000;

endpackage

// File: rtl/sync_chain.sv
// Plain flop shift chain bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the chain; reset loads the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Synchronizes a raw button level and commits a new clean level only after it holds
// DEBOUNCE_CYCLES samples in a row. Build option: DEBOUNCE_ACTIVE_LOW_EN (active-low raw_in).
module key_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    localparam logic RAW_IDLE = 1'b1;
`else
    localparam logic RAW_IDLE = 1'b0;
`endif

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("key_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             sync_s;
    logic             din_s;
    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, next_cnt_s;
    logic             clean_r, next_clean_s;
    logic             changed_r, next_changed_s;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RAW_IDLE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_s)
    );

    // XOR with the idle level makes din active-high in both builds.
    assign din_s = sync_s ^ RAW_IDLE;

    // Next-state, counter and output decisions for the confirmation FSM.
    always_comb begin
        next_state_s   = state_r;
        next_cnt_s     = cnt_r;
        next_clean_s   = clean_r;
        next_changed_s = 1'b0;
        case (state_r)
            LOW_STABLE: begin
                if (din_s) begin
                    next_state_s = LOW_TO_HIGH;
                    next_cnt_s   = CNT_W'(1);
                end else begin
                    next_cnt_s   = '0;
                end
            end
            LOW_TO_HIGH: begin
                if (!din_s) begin
                    next_state_s = LOW_STABLE;
                    next_cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s   = HIGH_STABLE;
                    next_cnt_s     = '0;
                    next_clean_s   = 1'b1;
                    next_changed_s = 1'b1;
                end else begin
                    next_cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            HIGH_STABLE: begin
                if (!din_s) begin
                    next_state_s = HIGH_TO_LOW;
                    next_cnt_s   = CNT_W'(1);
                end else begin
                    next_cnt_s   = '0;
                end
            end
            HIGH_TO_LOW: begin
                if (din_s) begin
                    next_state_s = HIGH_STABLE;
                    next_cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s   = LOW_STABLE;
                    next_cnt_s     = '0;
                    next_clean_s   = 1'b0;
                    next_changed_s = 1'b1;
                end else begin
                    next_cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_state_s = LOW_STABLE;
                next_cnt_s   = '0;
                next_clean_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= LOW_STABLE;
            cnt_r     <= '0;
            clean_r   <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= next_cnt_s;
            clean_r   <= next_clean_s;
            changed_r <= next_changed_s;
        end
    end

    assign clean_out = clean_r;
    assign changed   = changed_r;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: run-length reference model, directed scenarios,
// then randomized bounce patterns with occasional resets. Works in both polarity builds.
module tb_key_debouncer;

    localparam int SS = 2;
    localparam int DC = 4;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif
    localparam logic IDLE = ACT_LOW;
    localparam logic ACTV = ~ACT_LOW;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic clean_out;
    logic changed;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    key_debouncer #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .changed   (changed)
    );

    always #50 clk = ~clk;

    // Reference: delay raw by SS samples, count consecutive samples disagreeing with the
    // committed level, flip the level when that run reaches DC.
    logic m_pipe [SS];
    logic m_clean   = 1'b0;
    logic m_changed = 1'b0;
    int   m_run     = 0;

    always @(posedge clk) begin
        logic d;
        if (reset) begin
            for (int i = 0; i < SS; i++) m_pipe[i] = IDLE;
            m_clean   = 1'b0;
            m_changed = 1'b0;
            m_run     = 0;
        end else begin
            d = m_pipe[SS-1] ^ ACT_LOW;
            for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = raw_in;
            m_changed = 1'b0;
            if (d != m_clean) begin
                m_run = m_run + 1;
                if (m_run == DC) begin
                    m_clean   = ~m_clean;
                    m_changed = 1'b1;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clean", clean_out, m_clean);
            check("model_changed", changed, m_changed);
        end
    end

    task automatic tick(input logic r, input logic rs);
        raw_in = r;
        reset  = rs;
        @(posedge clk);
        #10;
    endtask

    initial begin
        raw_in = IDLE;
        reset  = 1'b1;

        // 1: reset held three cycles with idle input
        for (int k = 1; k <= 3; k++) begin
            tick(IDLE, 1'b1);
            chk_en = 1'b1;
            check("rst_clean", clean_out, 1'b0);
            check("rst_changed", changed, 1'b0);
        end

        // 3: short press of three samples never commits
        for (int k = 1; k <= 3; k++) tick(ACTV, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick(IDLE, 1'b0);
            check("short_clean", clean_out, 1'b0);
            check("short_changed", changed, 1'b0);
        end

        // 2: held press commits after edge 6, single pulse
        for (int k = 1; k <= 6; k++) begin
            tick(ACTV, 1'b0);
            check("press_clean", clean_out, (k == 6));
            check("press_changed", changed, (k == 6));
        end
        check("model_pin_press", m_clean, 1'b1);
        tick(ACTV, 1'b0);
        check("press_pulse_end", changed, 1'b0);
        check("press_hold", clean_out, 1'b1);

        // 4: bouncing release, then a clean hold falls once after six edges
        tick(ACTV, 1'b0);
        tick(IDLE, 1'b0);
        tick(ACTV, 1'b0);
        check("bounce_clean", clean_out, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick(IDLE, 1'b0);
            check("release_clean", clean_out, (k < 6));
            check("release_changed", changed, (k == 6));
        end
        check("model_pin_release", m_clean, 1'b0);
        tick(IDLE, 1'b0);
        check("release_pulse_end", changed, 1'b0);

        // 5: reset at edge 4 of a held press aborts it; requalifies afterwards
        for (int k = 1; k <= 3; k++) tick(ACTV, 1'b0);
        tick(ACTV, 1'b1);
        check("midrst_clean", clean_out, 1'b0);
        check("midrst_changed", changed, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick(ACTV, 1'b0);
            check("requal_clean", clean_out, (k == 6));
            check("requal_changed", changed, (k == 6));
        end

        // Randomized runs of bouncing levels with occasional single-cycle resets
        for (int n = 0; n < 400; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                tick(v, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
            end
        end

        tick(raw_in, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
